// File: rtl/snn_pkg.sv
// snn_pkg: constants and loader state type shared by the snn input path
package snn_pkg;
    localparam int NUM_PIXELS = 784;
    localparam int ADDR_W = 10;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, START, WAIT_DONE} loader_state_t;
endpackage

// File: rtl/input_unit_loader.sv
// input_unit_loader: unpacks UART bytes into the 784x1 input RAM and starts snn_core
module input_unit_loader
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_rdy,
    output logic              rx_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              ram_we,
    output logic              start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic [3:0]        digit,
    output logic              digit_vld
);
    localparam int BIT_W = $clog2(BYTE_W);
    localparam logic [ADDR_W-1:0] last_pix = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [BIT_W-1:0] last_bit = BIT_W'(BYTE_W - 1);

    loader_state_t     state;
    logic [BYTE_W-1:0] shreg;
    logic [ADDR_W-1:0] pix_cnt;
    logic [BIT_W-1:0]  bit_cnt;

    // accept a byte, serialise it LSB-first into the RAM, then hand the image to the core
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            pix_cnt   <= '0;
            bit_cnt   <= '0;
            rx_clr    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= 1'b0;
            start     <= 1'b0;
            digit     <= '0;
            digit_vld <= 1'b0;
        end else begin
            rx_clr <= 1'b0;
            ram_we <= 1'b0;
            start  <= 1'b0;
            case (state)
                IDLE: if (rx_rdy) begin
                    shreg   <= rx_data;
                    rx_clr  <= 1'b1;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                    if (pix_cnt == '0) digit_vld <= 1'b0;
                end
                SHIFT: begin
                    ram_we   <= 1'b1;
                    ram_data <= shreg[0];
                    ram_addr <= pix_cnt;
                    shreg    <= shreg >> 1;
                    bit_cnt  <= bit_cnt + 1'b1;
                    pix_cnt  <= (pix_cnt == last_pix) ? pix_cnt : pix_cnt + 1'b1;
                    if (bit_cnt == last_bit) state <= (pix_cnt == last_pix) ? START : IDLE;
                end
                START: begin
                    start   <= 1'b1;
                    pix_cnt <= '0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: if (core_done) begin
                    digit     <= core_digit;
                    digit_vld <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_unit_loader.sv
// tb_input_unit_loader: directed vectors and image streams against input_unit_loader
module tb_input_unit_loader;
    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] rx_data = 0;
    logic       rx_rdy = 0;
    logic       rx_clr;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       ram_we;
    logic       start;
    logic       core_done = 0;
    logic [3:0] core_digit = 0;
    logic [3:0] digit;
    logic       digit_vld;

    input_unit_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_clr(rx_clr),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .start(start),
        .core_done(core_done), .core_digit(core_digit), .digit(digit), .digit_vld(digit_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int exp_addr = 0;
    bit mon_en = 0;
    logic [7:0] img_bytes [98];
    logic ram_model [784];

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    function automatic logic img_bit(input int a);
        logic [7:0] b;
        b = img_bytes[a / 8];
        return b[a % 8];
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ram_we) begin
            ram_model[ram_addr] = ram_data;
            wr_cnt++;
        end
        if (start) start_cnt++;
    end

    always @(negedge clk) begin
        if (mon_en && ram_we) begin
            chk("wr_addr", int'(ram_addr), exp_addr);
            chk("wr_data", int'(ram_data), int'(img_bit(exp_addr < 784 ? exp_addr : 0)));
            exp_addr++;
        end
    end

    task automatic chk_reset_vals();
        chk("rst_rx_clr", int'(rx_clr), 0);
        chk("rst_ram_we", int'(ram_we), 0);
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_data", int'(ram_data), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_digit_vld", int'(digit_vld), 0);
    endtask

    task automatic wait_clr(output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_clr && n < 30);
        chk("clr_seen", int'(rx_clr), 1);
        t = cyc;
    endtask

    task automatic pulse_done(input logic [3:0] d);
        core_done = 1;
        core_digit = d;
        @(negedge clk);
        core_done = 0;
    endtask

    task automatic prep_image();
        for (int i = 0; i < 784; i++) ram_model[i] = ~img_bit(i);
        wr_cnt = 0;
        start_cnt = 0;
        exp_addr = 0;
        mon_en = 1;
    endtask

    task automatic stream(input int from);
        int t, prev, n;
        t = 0;
        prev = 0;
        rx_rdy = 1;
        for (int k = from; k < 98; k++) begin
            rx_data = img_bytes[k];
            wait_clr(t);
            if (k > from) chk("clr_gap", t - prev, 9);
            prev = t;
        end
        rx_rdy = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!start && n < 20);
        chk("start_seen", int'(start), 1);
        chk("start_lat", cyc - prev, 9);
        repeat (6) @(negedge clk);
        chk("start_count", start_cnt, 1);
        chk("write_count", wr_cnt, 784);
        chk("last_addr", exp_addr, 784);
        n = 0;
        for (int i = 0; i < 784; i++) if (ram_model[i] !== img_bit(i)) n++;
        chk("ram_image_errors", n, 0);
    endtask

    initial begin
        vec_t vecs[6];
        int t, n;
        vecs[0] = '{8'hA5, 8'b10100101};
        vecs[1] = '{8'h01, 8'b10000000};
        vecs[2] = '{8'h80, 8'b00000001};
        vecs[3] = '{8'hF0, 8'b00001111};
        vecs[4] = '{8'h96, 8'b01101001};
        vecs[5] = '{8'h3C, 8'b00111100};

        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 0;
        @(negedge clk);
        pulse_done(4'd9);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            rx_data = vecs[v].data;
            rx_rdy = 1;
            wait_clr(t);
            rx_rdy = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                chk("vec_we", int'(ram_we), 1);
                chk("vec_addr", int'(ram_addr), v * 8 + i);
                chk("vec_data", int'(ram_data), int'(vecs[v].seq[7 - i]));
                if (v == 2 && i == 2) begin
                    core_done = 1;
                    core_digit = 4'd9;
                end else core_done = 0;
            end
            @(negedge clk);
            chk("vec_idle_we", int'(ram_we), 0);
        end
        chk("spurious_digit", int'(digit), 0);
        chk("spurious_vld", int'(digit_vld), 0);

        for (int k = 6; k < 40; k++) begin
            rx_data = 8'hA5;
            rx_rdy = 1;
            wait_clr(t);
            rx_rdy = 0;
            repeat (8) @(negedge clk);
        end
        rx_rdy = 1;
        wait_clr(t);
        rx_rdy = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk_reset_vals();
        chk("no_start_partial", start_cnt, 0);
        rst = 0;

        for (int k = 0; k < 98; k++) img_bytes[k] = 8'hA5;
        prep_image();
        stream(0);

        for (int k = 0; k < 98; k++) img_bytes[k] = 8'((k * 37 + 5) & 255);
        img_bytes[0] = 8'h3C;
        prep_image();
        rx_data = 8'h3C;
        rx_rdy = 1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (rx_clr) n++;
        end
        chk("backpressure_clr", n, 0);
        chk("pre_done_vld", int'(digit_vld), 0);
        pulse_done(4'd7);
        chk("done_digit", int'(digit), 7);
        chk("done_vld", int'(digit_vld), 1);
        chk("done_no_clr", int'(rx_clr), 0);
        @(negedge clk);
        chk("after_done_clr", int'(rx_clr), 1);
        chk("vld_cleared", int'(digit_vld), 0);
        chk("digit_kept", int'(digit), 7);
        rx_rdy = 0;
        repeat (8) @(negedge clk);
        stream(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
